i2c_boot_bridge: RTL

Parametrised bridge between the I2C slave and the bootloader state machine. It forwards I2C write bytes straight to the bootloader and captures bootloader responses in a buffer. I2C reads return an optional status byte, then the buffered bytes, then a fill pattern. It adds overflow detection, a byte count and a real read-valid handshake.

---
 rtl/i2c_boot_bridge_pkg.sv | 24 ++
 rtl/i2c_boot_bridge_ram.sv | 33 +++
 rtl/i2c_boot_bridge.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_boot_bridge_pkg.sv
// i2c_boot_bridge_pkg
// Shared types and constants for the I2C boot bridge.
//   rd_state_t    : read-side FSM states
//   ST_*          : status bit positions, counted down from the MSB
//                   (bit index = DATA_W - ST_*)
//   status_bit()  : turns an ST_* offset into an absolute bit index
package i2c_boot_bridge_pkg;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STATUS = 2'd1,
        RD_DATA   = 2'd2,
        RD_FILL   = 2'd3
    } rd_state_t;

    localparam int ST_BUSY     = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_NONEMPTY = 3;

    function automatic int status_bit(input int data_w, input int offset);
        return data_w - offset;
    endfunction

endpackage

// File: rtl/i2c_boot_bridge_ram.sv
// boot_buffer_ram
// Simple dual-port buffer, DEPTH x DATA_W. Synchronous write, registered
// one-cycle read, no reset so it maps onto block RAM.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable,  raddr       : read address
//   rdata : read data, valid the cycle after re
module boot_buffer_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/i2c_boot_bridge.sv
// i2c_boot_bridge
// Bridge between the I2C slave and the bootloader. I2C write bytes pass
// straight through to the bootloader; bootloader response bytes are captured
// in a buffer and returned on I2C reads as [status byte], buffer bytes, then
// FILL forever.
//   clk, rst_n                  : clock, async active-low reset
//   bl_out_valid/data/ready     : bootloader response stream (ready tied 1)
//   bl_in_valid/data/ready      : command stream to the bootloader
//   bl_busy                     : bootloader busy, reported in status
//   bl_reset                    : bootloader reset, = i2c_write
//   i2c_write_valid/data/ready  : bytes written by the I2C master
//   i2c_read_valid/data/ready   : bytes presented to the I2C slave
//   i2c_read, i2c_write         : transaction start pulses
//   count                       : bytes currently held in the buffer
//
// Read handshake: a byte is transferred when i2c_read_valid && i2c_read_ready
// on a rising edge. Data and valid stay stable until accepted or until
// i2c_read restarts the transaction.
module i2c_boot_bridge
    import i2c_boot_bridge_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH = 15360,
    parameter int STATUS_EN = 1,
    parameter logic [DATA_W-1:0] FILL = {DATA_W{1'b1}},
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bl_out_valid,
    input  logic [DATA_W-1:0] bl_out_data,
    output logic              bl_out_ready,
    output logic              bl_in_valid,
    output logic [DATA_W-1:0] bl_in_data,
    input  logic              bl_in_ready,
    input  logic              bl_busy,
    output logic              bl_reset,
    output logic              i2c_write_ready,
    input  logic [DATA_W-1:0] i2c_write_data,
    input  logic              i2c_write_valid,
    input  logic              i2c_read_ready,
    output logic [DATA_W-1:0] i2c_read_data,
    output logic              i2c_read_valid,
    input  logic              i2c_read,
    input  logic              i2c_write,
    output logic [CW-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam int B_BUSY     = status_bit(DATA_W, ST_BUSY);
    localparam int B_OVF      = status_bit(DATA_W, ST_OVF);
    localparam int B_NONEMPTY = status_bit(DATA_W, ST_NONEMPTY);

    rd_state_t         state, next_state;
    logic [CW-1:0]     wr_ptr, rd_ptr, fetch_addr;
    logic              overflow, load_pending;
    logic              accept, fetch, hit, we;
    logic [DATA_W-1:0] ram_q, status_byte;

    // Pass-through paths
    assign bl_out_ready    = 1'b1;
    assign bl_in_valid     = i2c_write_valid;
    assign bl_in_data      = i2c_write_data;
    assign bl_reset        = i2c_write;
    assign i2c_write_ready = bl_in_ready;
    assign count           = wr_ptr;

    assign accept = i2c_read_valid && i2c_read_ready;
    // i2c_write resets the bootloader, so a same-cycle beat is discarded
    assign we     = bl_out_valid && !i2c_write && (wr_ptr < DEPTH_C);

    always_comb begin
        status_byte             = '0;
        status_byte[B_BUSY]     = bl_busy;
        status_byte[B_OVF]      = overflow;
        status_byte[B_NONEMPTY] = (wr_ptr != '0);
    end

    boot_buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bl_out_data),
        .re    (fetch && hit),
        .raddr (fetch_addr[AW-1:0]),
        .rdata (ram_q)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state. A fetch decides DATA vs FILL using the wr_ptr seen in
    // the fetch cycle, so any byte it selects is already in the RAM.
    always_comb begin
        next_state = state;
        if (i2c_read) begin
            if (STATUS_EN != 0) begin
                next_state = RD_STATUS;
            end else begin
                next_state = hit ? RD_DATA : RD_FILL;
            end
        end else if (accept) begin
            case (state)
                RD_STATUS, RD_DATA: next_state = hit ? RD_DATA : RD_FILL;
                default:            next_state = state;
            endcase
        end
    end

    // FSM: outputs. A fetch issues the RAM read for the next byte; the byte
    // lands in the output register one cycle later.
    always_comb begin
        fetch      = 1'b0;
        fetch_addr = rd_ptr;
        if (i2c_read) begin
            fetch      = 1'b1;
            fetch_addr = '0;
        end else if (accept) begin
            fetch = 1'b1;
            case (state)
                RD_STATUS: fetch_addr = '0;
                RD_DATA:   fetch_addr = rd_ptr + CW'(1);
                default:   fetch_addr = rd_ptr;
            endcase
        end
        hit = (fetch_addr < wr_ptr);
    end

    // Write side: pointer never wraps, full buffer drops and flags overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else if (i2c_write) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else if (bl_out_valid) begin
            if (wr_ptr < DEPTH_C) begin
                wr_ptr <= wr_ptr + CW'(1);
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Read side: valid drops on every fetch and rises one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr         <= '0;
            load_pending   <= 1'b0;
            i2c_read_valid <= 1'b0;
            i2c_read_data  <= '0;
        end else begin
            load_pending <= fetch;
            if (fetch) begin
                rd_ptr         <= fetch_addr;
                i2c_read_valid <= 1'b0;
            end else if (load_pending) begin
                i2c_read_valid <= 1'b1;
                case (state)
                    RD_STATUS: i2c_read_data <= status_byte;
                    RD_DATA:   i2c_read_data <= ram_q;
                    RD_FILL:   i2c_read_data <= FILL;
                    default:   i2c_read_data <= i2c_read_data;
                endcase
            end
        end
    end

endmodule
